// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: multi-mode VGA test-pattern generator.
// Consumes pixel coordinates and display-enable from the timing block and
// produces registered RGB one clock later. The pattern mode changes only at
// end of frame. The moving-bar mode is animated by a per-frame position.
//
// Ports:
//   clk          pixel clock, rising edge
//   rst          asynchronous active-high reset
//   x, y         pixel column / row from the timing block
//   disp_enable  high inside the active display area
//   mode_sel     requested pattern mode
//   mode_req     one-cycle strobe that captures mode_sel
//   r, g, b      registered colour channels, CW bits each
//   de_out       disp_enable delayed to line up with r/g/b
//   mode_cur     mode currently being drawn
//   frame_cnt    completed-frame counter, wraps at 16 bits
module vga_pattern_gen #(
  parameter int H_DISP    = 640,
  parameter int V_DISP    = 480,
  parameter int CW        = 4,
  parameter int BORDER    = 4,
  parameter int SQ_LOG2   = 5,
  parameter int BAR_W     = 32,
  parameter int STEP      = 4,
  parameter int INIT_MODE = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   x,
  input  logic [31:0]   y,
  input  logic          disp_enable,
  input  logic [2:0]    mode_sel,
  input  logic          mode_req,
  output logic [CW-1:0] r,
  output logic [CW-1:0] g,
  output logic [CW-1:0] b,
  output logic          de_out,
  output logic [2:0]    mode_cur,
  output logic [15:0]   frame_cnt
);

  typedef enum logic [2:0] {
    MODE_QUAD  = 3'd0,
    MODE_BARS  = 3'd1,
    MODE_CHECK = 3'd2,
    MODE_RAMP  = 3'd3,
    MODE_BAR   = 3'd4,
    MODE_WHITE = 3'd5,
    MODE_RSV6  = 3'd6,
    MODE_RSV7  = 3'd7
  } mode_t;

  localparam mode_t         INIT_M = mode_t'(INIT_MODE[2:0]);
  localparam logic [31:0]   HD     = 32'(H_DISP);
  localparam logic [31:0]   VD     = 32'(V_DISP);
  localparam logic [35:0]   HD36   = 36'(H_DISP);
  localparam logic [31:0]   HX     = 32'(H_DISP / 2);
  localparam logic [31:0]   VY     = 32'(V_DISP / 2);
  localparam logic [31:0]   HX_LO  = 32'(H_DISP / 2 - BORDER);
  localparam logic [31:0]   HX_HI  = 32'(H_DISP / 2 + BORDER);
  localparam logic [31:0]   VY_LO  = 32'(V_DISP / 2 - BORDER);
  localparam logic [31:0]   VY_HI  = 32'(V_DISP / 2 + BORDER);
  localparam logic [31:0]   H_LAST = 32'(H_DISP - 1);
  localparam logic [31:0]   V_LAST = 32'(V_DISP - 1);
  localparam logic [31:0]   BW     = 32'(BAR_W);
  localparam logic [31:0]   STP    = 32'(STEP);
  localparam logic [CW-1:0] FULL   = '1;
  localparam logic [CW-1:0] ZERO   = '0;

  mode_t       mode_q;
  mode_t       pend_q;
  logic [31:0] pos;

  logic          eof;
  logic          in_area;
  logic [2:0]    bar_idx;
  logic [CW-1:0] ramp;
  logic [31:0]   dx;
  logic [31:0]   pos_nxt;
  logic [CW-1:0] r_d, g_d, b_d;

  assign eof     = disp_enable && (x == H_LAST) && (y == V_LAST);
  assign in_area = disp_enable && (x < HD) && (y < VD);

  always_comb begin
    // 36-bit intermediates keep x*8 and x<<CW exact for any 32-bit x.
    bar_idx = 3'(((36'(x)) << 3) / HD36);
    ramp    = CW'(((36'(x)) << CW) / HD36);
    // (x - pos) mod H_DISP without going negative; valid for x < H_DISP,
    // out-of-range pixels are blanked below anyway.
    dx      = (x >= pos) ? (x - pos) : (x + HD - pos);
    pos_nxt = (pos + STP >= HD) ? (pos + STP - HD) : (pos + STP);

    {r_d, g_d, b_d} = {ZERO, ZERO, ZERO};
    case (mode_q)
      MODE_QUAD: begin
        if ((x >= HX_LO && x < HX_HI) || (y >= VY_LO && y < VY_HI)) begin
          {r_d, g_d, b_d} = {FULL, FULL, FULL};
        end else begin
          case ({x >= HX, y >= VY})
            2'b00:   {r_d, g_d, b_d} = {FULL, ZERO, ZERO};
            2'b10:   {r_d, g_d, b_d} = {ZERO, ZERO, FULL};
            2'b01:   {r_d, g_d, b_d} = {ZERO, FULL, ZERO};
            default: {r_d, g_d, b_d} = {ZERO, ZERO, ZERO};
          endcase
        end
      end
      MODE_BARS: begin
        case (bar_idx)
          3'd0:    {r_d, g_d, b_d} = {FULL, FULL, FULL};
          3'd1:    {r_d, g_d, b_d} = {FULL, FULL, ZERO};
          3'd2:    {r_d, g_d, b_d} = {ZERO, FULL, FULL};
          3'd3:    {r_d, g_d, b_d} = {ZERO, FULL, ZERO};
          3'd4:    {r_d, g_d, b_d} = {FULL, ZERO, FULL};
          3'd5:    {r_d, g_d, b_d} = {FULL, ZERO, ZERO};
          3'd6:    {r_d, g_d, b_d} = {ZERO, ZERO, FULL};
          default: {r_d, g_d, b_d} = {ZERO, ZERO, ZERO};
        endcase
      end
      MODE_CHECK: begin
        if ((x[SQ_LOG2] ^ y[SQ_LOG2]) == 1'b0)
          {r_d, g_d, b_d} = {FULL, FULL, FULL};
      end
      MODE_RAMP: begin
        {r_d, g_d, b_d} = {ramp, ramp, ramp};
      end
      MODE_BAR: begin
        if (dx < BW) {r_d, g_d, b_d} = {FULL, FULL, FULL};
        else         {r_d, g_d, b_d} = {ZERO, ZERO, FULL};
      end
      MODE_WHITE: begin
        {r_d, g_d, b_d} = {FULL, FULL, FULL};
      end
      default: begin
        {r_d, g_d, b_d} = {ZERO, ZERO, ZERO};
      end
    endcase

    if (!in_area) {r_d, g_d, b_d} = {ZERO, ZERO, ZERO};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r         <= '0;
      g         <= '0;
      b         <= '0;
      de_out    <= 1'b0;
      frame_cnt <= '0;
      pos       <= '0;
      mode_q    <= INIT_M;
      pend_q    <= INIT_M;
    end else begin
      r      <= r_d;
      g      <= g_d;
      b      <= b_d;
      de_out <= disp_enable;
      if (mode_req) pend_q <= mode_t'(mode_sel);
      if (eof) begin
        frame_cnt <= frame_cnt + 16'd1;
        pos       <= pos_nxt;
        // A request landing on the EOF cycle itself goes straight to the
        // drawn mode; otherwise the last pending request is applied.
        mode_q    <= mode_req ? mode_t'(mode_sel) : pend_q;
      end
    end
  end

  assign mode_cur = mode_q;

endmodule
